slot_status_register: RTL and testbench

- Parametrised successor to the 8-bit enable register. Holds per-slot occupancy bits for the parking lot.
- Supports per-slot set (car enters) and clear (car leaves), plus parallel load.
- Keeps a registered occupancy count, full/empty flags, lowest-free-slot index and a sticky error flag.
- Sits between the gate/sensor controllers and the display/allocation logic.

---
 rtl/slot_pkg.sv | 44 ++++
 rtl/slot_priority_encoder.sv | 31 +++
 rtl/slot_status_register.sv | 120 ++++++++++++
 tb/tb_slot_status_register.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/slot_pkg.sv
// Shared definitions for the parking-lot slot status register.
// Purpose: default slot count, maximum supported widths, and the two helper
// functions (popcount, lowest_zero) used by the register and its encoder.
// Helpers operate on a MAX_SLOTS-wide vector. Callers widen their own
// vector before the call and narrow the result afterwards.
package slot_pkg;

  localparam int DEFAULT_NUM_SLOTS = 8;
  localparam int MAX_SLOTS         = 64;
  localparam int MAX_IDX_W         = 6;
  localparam int MAX_CNT_W         = 7;

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] idx;
  } lowest_zero_t;

  // Number of ones in the vector. 64 fits in 7 bits, so the sum never wraps.
  function automatic logic [MAX_CNT_W-1:0] popcount(input logic [MAX_SLOTS-1:0] vec);
    logic [MAX_CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_SLOTS; i++) begin
      cnt = cnt + MAX_CNT_W'(vec[i]);
    end
    return cnt;
  endfunction

  // The scan runs from the top down, so the last zero it finds is the
  // lowest one. This resolves ties toward index 0. idx stays 0 when no zero
  // exists.
  function automatic lowest_zero_t lowest_zero(input logic [MAX_SLOTS-1:0] vec);
    lowest_zero_t r;
    r.valid = 1'b0;
    r.idx   = '0;
    for (int i = MAX_SLOTS - 1; i >= 0; i--) begin
      if (!vec[i]) begin
        r.valid = 1'b1;
        r.idx   = MAX_IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/slot_priority_encoder.sv
// Lowest-free-slot priority encoder.
// Purpose: finds the lowest index whose occupancy bit is 0.
// Ports:
//   vec        occupancy vector, bit i = slot i occupied
//   free_valid at least one slot is free
//   free_idx   lowest free slot index, 0 when free_valid is 0
module slot_priority_encoder
  import slot_pkg::*;
#(
  parameter  int NUM_SLOTS = DEFAULT_NUM_SLOTS,
  localparam int IDX_W     = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] vec,
  output logic                 free_valid,
  output logic [IDX_W-1:0]     free_idx
);

  logic [MAX_SLOTS-1:0] padded;
  lowest_zero_t         lz;

  // The unused upper positions are padded with ones, which makes them look
  // occupied. This keeps them from being reported as free.
  always_comb begin
    padded                = '1;
    padded[NUM_SLOTS-1:0] = vec;
    lz                    = lowest_zero(padded);
    free_valid            = lz.valid;
    free_idx              = IDX_W'(lz.idx);
  end

endmodule

// File: rtl/slot_status_register.sv
// Parking-lot slot status register.
// Purpose: holds one occupancy bit per slot. It supports per-slot set and
// clear requests and a parallel load. It keeps a registered count,
// full/empty flags, the lowest free slot and a sticky protocol-error flag.
// Every registered output is derived from the same next-state vector, so
// none of them lags Q by a cycle.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   en                  global enable (0 = hold everything)
//   load, D             parallel load of the occupancy vector
//   set_valid, set_idx  mark a slot occupied
//   clr_valid, clr_idx  mark a slot free
//   Q, count            occupancy vector and its popcount
//   full, empty         all / no slots occupied
//   free_valid,free_idx lowest free slot (idx 0 when none free)
//   err                 sticky error; cleared by RST or load
module slot_status_register
  import slot_pkg::*;
#(
  parameter  int NUM_SLOTS = DEFAULT_NUM_SLOTS,
  localparam int IDX_W     = $clog2(NUM_SLOTS),
  localparam int CNT_W     = $clog2(NUM_SLOTS + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 en,
  input  logic                 load,
  input  logic [NUM_SLOTS-1:0] D,
  input  logic                 set_valid,
  input  logic [IDX_W-1:0]     set_idx,
  input  logic                 clr_valid,
  input  logic [IDX_W-1:0]     clr_idx,
  output logic [NUM_SLOTS-1:0] Q,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty,
  output logic                 free_valid,
  output logic [IDX_W-1:0]     free_idx,
  output logic                 err
);

  logic                 set_in_range;
  logic                 clr_in_range;
  logic [NUM_SLOTS-1:0] set_mask;
  logic [NUM_SLOTS-1:0] clr_mask;
  logic                 same_slot;
  logic [NUM_SLOTS-1:0] next_q;
  logic                 next_err;
  logic                 next_free_valid;
  logic [IDX_W-1:0]     next_free_idx;

  // An index is in range only when it is below NUM_SLOTS. The check matters
  // only when NUM_SLOTS is not a power of 2. Requests with an out-of-range
  // index get an empty mask, so they cannot touch Q.
  always_comb begin
    set_in_range = {1'b0, set_idx} < (IDX_W + 1)'(NUM_SLOTS);
    clr_in_range = {1'b0, clr_idx} < (IDX_W + 1)'(NUM_SLOTS);
    set_mask     = set_in_range ? (NUM_SLOTS'(1) << set_idx) : '0;
    clr_mask     = clr_in_range ? (NUM_SLOTS'(1) << clr_idx) : '0;
    same_slot    = set_valid && clr_valid && set_in_range && (set_idx == clr_idx);
  end

  // Set and clear are each checked against the current Q, not against each
  // other's result. When both target the same slot they cancel, and no
  // error is raised.
  always_comb begin
    next_q   = Q;
    next_err = err;
    if (load) begin
      next_q   = D;
      next_err = 1'b0;
    end else if (!same_slot) begin
      if (set_valid) begin
        if (!set_in_range || ((Q & set_mask) != '0)) begin
          next_err = 1'b1;
        end else begin
          next_q = next_q | set_mask;
        end
      end
      if (clr_valid) begin
        if (!clr_in_range || ((Q & clr_mask) == '0)) begin
          next_err = 1'b1;
        end else begin
          next_q = next_q & ~clr_mask;
        end
      end
    end
  end

  slot_priority_encoder #(
    .NUM_SLOTS(NUM_SLOTS)
  ) u_free_enc (
    .vec       (next_q),
    .free_valid(next_free_valid),
    .free_idx  (next_free_idx)
  );

  // Every output is registered from next_q in the same edge. count is
  // recomputed from next_q rather than incremented, so it cannot wrap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Q          <= '0;
      count      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      free_valid <= 1'b1;
      free_idx   <= '0;
      err        <= 1'b0;
    end else if (en) begin
      Q          <= next_q;
      count      <= CNT_W'(popcount(MAX_SLOTS'(next_q)));
      full       <= (next_q == '1);
      empty      <= (next_q == '0);
      free_valid <= next_free_valid;
      free_idx   <= next_free_idx;
      err        <= next_err;
    end
  end

endmodule

// File: tb/tb_slot_status_register.sv
// Testbench for slot_status_register.
// Purpose: two instances, with 8 slots and 6 slots, share one input stream.
// A reference model of the occupancy rules predicts each instance's
// outputs. The model keeps one bit per slot in an array and derives the
// count, flags and free index by scanning that array. Predictions are queued
// when stimulus is issued. A monitor pops and compares them after each edge.
module tb_slot_status_register;

  logic       CLK = 1'b0;
  logic       RST;
  logic       en;
  logic       load;
  logic [7:0] d_in;
  logic       set_valid;
  logic [2:0] set_idx;
  logic       clr_valid;
  logic [2:0] clr_idx;

  logic [7:0] q8;
  logic [3:0] count8;
  logic       full8, empty8, fv8, err8;
  logic [2:0] fidx8;

  logic [5:0] q6;
  logic [2:0] count6;
  logic       full6, empty6, fv6, err6;
  logic [2:0] fidx6;

  typedef struct {
    logic [63:0] q;
    int          count;
    bit          full;
    bit          empty;
    bit          fv;
    int          fidx;
    bit          err;
  } exp_t;

  exp_t exp_q [2][$];

  bit occ [2][64];
  bit merr [2];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  slot_status_register #(.NUM_SLOTS(8)) u_dut8 (
    .CLK(CLK), .RST(RST), .en(en), .load(load), .D(d_in),
    .set_valid(set_valid), .set_idx(set_idx),
    .clr_valid(clr_valid), .clr_idx(clr_idx),
    .Q(q8), .count(count8), .full(full8), .empty(empty8),
    .free_valid(fv8), .free_idx(fidx8), .err(err8)
  );

  slot_status_register #(.NUM_SLOTS(6)) u_dut6 (
    .CLK(CLK), .RST(RST), .en(en), .load(load), .D(d_in[5:0]),
    .set_valid(set_valid), .set_idx(set_idx),
    .clr_valid(clr_valid), .clr_idx(clr_idx),
    .Q(q6), .count(count6), .full(full6), .empty(empty6),
    .free_valid(fv6), .free_idx(fidx6), .err(err6)
  );

  function automatic int nslots(input int m);
    return (m == 0) ? 8 : 6;
  endfunction

  // Model of one edge. It covers reset, hold, load, and independent set/clr
  // requests checked against the occupancy before the edge.
  task automatic modelStep(input int m, input bit rst, input bit e, input bit ld,
                           input logic [7:0] d, input bit sv, input int si,
                           input bit cv, input int ci);
    int n;
    bit cur [64];
    n = nslots(m);
    if (rst) begin
      for (int i = 0; i < 64; i++) occ[m][i] = 1'b0;
      merr[m] = 1'b0;
    end else if (e) begin
      if (ld) begin
        for (int i = 0; i < n; i++) occ[m][i] = d[i];
        merr[m] = 1'b0;
      end else if (!(sv && cv && si == ci && si < n)) begin
        for (int i = 0; i < 64; i++) cur[i] = occ[m][i];
        if (sv) begin
          if (si >= n || cur[si]) merr[m] = 1'b1;
          else occ[m][si] = 1'b1;
        end
        if (cv) begin
          if (ci >= n || !cur[ci]) merr[m] = 1'b1;
          else occ[m][ci] = 1'b0;
        end
      end
    end
  endtask

  function automatic exp_t predict(input int m);
    exp_t e;
    int   n;
    bool_found: begin end
    n = nslots(m);
    e.q = '0;
    e.count = 0;
    e.fidx = 0;
    e.fv = 1'b0;
    for (int i = 0; i < n; i++) begin
      e.q[i] = occ[m][i];
      e.count += occ[m][i] ? 1 : 0;
      if (!occ[m][i] && !e.fv) begin
        e.fv = 1'b1;
        e.fidx = i;
      end
    end
    e.full  = (e.count == n);
    e.empty = (e.count == 0);
    e.err   = merr[m];
    return e;
  endfunction

  // Drives one cycle of inputs, lets the edge happen, then queues what each
  // instance should show afterwards.
  task automatic applyStimulus(input bit rst, input bit e, input bit ld,
                               input logic [7:0] d, input bit sv, input int si,
                               input bit cv, input int ci);
    RST       = rst;
    en        = e;
    load      = ld;
    d_in      = d;
    set_valid = sv;
    set_idx   = 3'(si);
    clr_valid = cv;
    clr_idx   = 3'(ci);
    @(posedge CLK);
    for (int m = 0; m < 2; m++) begin
      modelStep(m, rst, e, ld, d, sv, si, cv, ci);
      exp_q[m].push_back(predict(m));
    end
    @(negedge CLK);
  endtask

  task automatic checkField(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input exp_t e, input logic [63:0] q,
                             input logic [63:0] cnt, input logic full, input logic empty,
                             input logic fv, input logic [63:0] fidx, input logic err);
    checkField({tag, ".Q"}, q, e.q);
    checkField({tag, ".count"}, cnt, 64'(e.count));
    checkField({tag, ".full"}, 64'(full), 64'(e.full));
    checkField({tag, ".empty"}, 64'(empty), 64'(e.empty));
    checkField({tag, ".free_valid"}, 64'(fv), 64'(e.fv));
    checkField({tag, ".free_idx"}, fidx, 64'(e.fidx));
    checkField({tag, ".err"}, 64'(err), 64'(e.err));
  endtask

  // Monitor: outputs are registered, so they are stable at the falling edge.
  always @(negedge CLK) begin
    exp_t e;
    if (exp_q[0].size() > 0) begin
      e = exp_q[0].pop_front();
      checkOutput("n8", e, 64'(q8), 64'(count8), full8, empty8, fv8, 64'(fidx8), err8);
    end
    if (exp_q[1].size() > 0) begin
      e = exp_q[1].pop_front();
      checkOutput("n6", e, 64'(q6), 64'(count6), full6, empty6, fv6, 64'(fidx6), err6);
    end
  end

  initial begin
    RST = 1'b1; en = 1'b0; load = 1'b0; d_in = '0;
    set_valid = 1'b0; set_idx = '0; clr_valid = 1'b0; clr_idx = '0;
    @(negedge CLK);

    // reset, then a dropped request while disabled
    applyStimulus(1, 0, 0, 8'h00, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 8'h00, 1, 0, 0, 0);

    // sequential fill
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 8'h00, 1, i, 0, 0);

    // load and clear
    applyStimulus(0, 1, 1, 8'b1011_0111, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 8'h00, 0, 0, 1, 5);

    // simultaneous set/clr, different and same index
    applyStimulus(0, 1, 1, 8'h0F, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 8'h00, 1, 4, 1, 1);
    applyStimulus(0, 1, 0, 8'h00, 1, 2, 1, 2);

    // errors and sticky behaviour
    applyStimulus(0, 1, 1, 8'h01, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 8'h00, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 8'h00, 0, 0, 1, 3);
    applyStimulus(0, 1, 1, 8'h00, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 8'h00, 1, 7, 0, 0);

    // reset beats a load and a set, then the next request applies normally
    applyStimulus(0, 1, 1, 8'hFF, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 8'hAA, 1, 3, 0, 0);
    applyStimulus(0, 1, 0, 8'h00, 1, 3, 0, 0);

    // randomized traffic
    for (int k = 0; k < 500; k++) begin
      applyStimulus($urandom_range(0, 99) < 2,
                    $urandom_range(0, 99) < 85,
                    $urandom_range(0, 99) < 8,
                    8'($urandom),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 7));
    end

    for (int k = 0; k < 5 && (exp_q[0].size() + exp_q[1].size()) > 0; k++) @(negedge CLK);
    #1;
    if ((exp_q[0].size() + exp_q[1].size()) > 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain: %0d predictions left, expected 0",
               exp_q[0].size() + exp_q[1].size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
